// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
//
// Iterative RV32M divide/remainder unit that sits in the EX stage next to the
// integer ALU. It executes DIV, DIVU, REM and REMU with a restoring algorithm
// and retires one quotient bit per clock. Divide-by-zero and signed overflow
// are resolved in a single edge without iterating.
//
// Ports
//   CLK     in   1     clock, all state changes on the rising edge
//   RESET   in   1     synchronous active-high reset
//   START   in   1     request a division, only looked at in IDLE
//   DIV_OP  in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU (captured with START)
//   DATA1   in   XLEN  dividend (captured with START)
//   DATA2   in   XLEN  divisor  (captured with START)
//   FLUSH   in   1     abort any in-flight operation, return to IDLE
//   BUSY    out  1     high while iterating (state CALC)
//   DONE    out  1     one-cycle pulse while in FIN
//   RESULT  out  XLEN  quotient or remainder, held until the next result
// ---------------------------------------------------------------------------
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [1:0]      DIV_OP,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    input  logic            FLUSH,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);

    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } state_t;

    state_t state;
    state_t state_next;

    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  div_mag;
    logic [CNT_W-1:0] count;
    logic             neg_quo;
    logic             neg_rem;
    logic             want_rem;
    logic [XLEN-1:0]  result_q;

    // Operand decode for the capture cycle. DIV_OP[0] clear means a signed
    // op, DIV_OP[1] set means the remainder is wanted.
    logic            op_signed;
    logic            op_rem;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            overflow;
    logic            special;
    logic [XLEN-1:0] special_result;
    logic            accept;

    // Two's-complement negation of the most negative value yields the same
    // bit pattern, which read as unsigned is exactly 2^(XLEN-1), so a plain
    // XLEN-bit unsigned magnitude is enough.
    always_comb begin
        op_signed      = ~DIV_OP[0];
        op_rem         = DIV_OP[1];
        a_neg          = op_signed & DATA1[XLEN-1];
        b_neg          = op_signed & DATA2[XLEN-1];
        a_mag          = a_neg ? (~DATA1 + 1'b1) : DATA1;
        b_mag          = b_neg ? (~DATA2 + 1'b1) : DATA2;
        div_zero       = (DATA2 == '0);
        overflow       = op_signed
                         && (DATA1 == {1'b1, {(XLEN-1){1'b0}}})
                         && (DATA2 == {XLEN{1'b1}});
        special        = div_zero | overflow;
        special_result = '0;
        if (div_zero) begin
            special_result = op_rem ? DATA1 : {XLEN{1'b1}};
        end else if (overflow) begin
            special_result = op_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
        accept         = START & ~FLUSH;
    end

    // One restoring step. The partial remainder is always below the divisor,
    // so after the shift it needs one extra bit; when the trial subtraction
    // succeeds the difference is again below the divisor and fits XLEN bits.
    logic [XLEN:0]   shifted;
    logic            fits;
    logic [XLEN-1:0] step_rem;
    logic [XLEN-1:0] step_quo;
    logic [XLEN-1:0] final_quo;
    logic [XLEN-1:0] final_rem;
    logic [XLEN-1:0] final_result;

    always_comb begin
        shifted      = {rem_q, quo_q[XLEN-1]};
        fits         = (shifted >= {1'b0, div_mag});
        step_rem     = fits ? (shifted[XLEN-1:0] - div_mag) : shifted[XLEN-1:0];
        step_quo     = {quo_q[XLEN-2:0], fits};
        final_quo    = neg_quo ? (~step_quo + 1'b1) : step_quo;
        final_rem    = neg_rem ? (~step_rem + 1'b1) : step_rem;
        final_result = want_rem ? final_rem : final_quo;
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. FLUSH beats everything except RESET; FIN always
    // falls back to IDLE so DONE is a single-cycle pulse.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = special ? FIN : CALC;
                end
            end
            CALC: begin
                if (FLUSH) begin
                    state_next = IDLE;
                end else if (count == '0) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath. RESULT is only written on a special-case capture or on the
    // final iteration, so an aborted operation leaves it untouched.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rem_q    <= '0;
            quo_q    <= '0;
            div_mag  <= '0;
            count    <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            want_rem <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (special) begin
                            result_q <= special_result;
                        end else begin
                            rem_q    <= '0;
                            quo_q    <= a_mag;
                            div_mag  <= b_mag;
                            count    <= CNT_W'(XLEN - 1);
                            neg_quo  <= a_neg ^ b_neg;
                            neg_rem  <= a_neg;
                            want_rem <= op_rem;
                        end
                    end
                end
                CALC: begin
                    if (!FLUSH) begin
                        rem_q <= step_rem;
                        quo_q <= step_quo;
                        count <= count - CNT_W'(1);
                        if (count == '0) begin
                            result_q <= final_result;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign BUSY   = (state == CALC);
    assign DONE   = (state == FIN);
    assign RESULT = result_q;

endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit
//
// Directed self-checking bench for div_unit. Each scenario task drives its
// own stimulus and compares against hand-computed values. Inputs change 1ns
// after a rising edge and outputs are sampled at that same point, well away
// from the edge itself.
// ---------------------------------------------------------------------------
module tb_div_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [1:0]  DIV_OP;
    logic [31:0] DATA1;
    logic [31:0] DATA2;
    logic        FLUSH;
    logic        BUSY;
    logic        DONE;
    logic [31:0] RESULT;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    always #5 CLK = ~CLK;

    div_unit #(.XLEN(32)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .DIV_OP (DIV_OP),
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .FLUSH  (FLUSH),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .RESULT (RESULT)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issues one operation and follows it to DONE (bounded). done_off is the
    // number of edges after the accepting edge E at which DONE was first seen
    // (0 = right after E). done_next is DONE one edge later.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int busy_cnt,
                          output int done_off, output logic [31:0] res,
                          output logic done_next);
        DIV_OP = op;
        DATA1  = a;
        DATA2  = b;
        START  = 1'b1;
        tick();
        START     = 1'b0;
        busy_cnt  = 0;
        done_off  = 0;
        res       = 'x;
        done_next = 1'bx;
        while (DONE !== 1'b1 && done_off < 100) begin
            if (BUSY === 1'b1) busy_cnt++;
            tick();
            done_off++;
        end
        if (DONE === 1'b1) begin
            res = RESULT;
            tick();
            done_next = DONE;
        end
    endtask

    task automatic test_reset();
        RESET  = 1'b1;
        START  = 1'b0;
        FLUSH  = 1'b0;
        DIV_OP = 2'b00;
        DATA1  = '0;
        DATA2  = '0;
        repeat (2) tick();
        checks++;
        if (BUSY !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_busy: got %b expected 0", BUSY);
        end
        checks++;
        if (DONE !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_done: got %b expected 0", DONE);
        end
        checks++;
        if (RESULT !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_result: got %h expected 00000000", RESULT);
        end
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_unsigned();
        int bc, off;
        logic [31:0] r;
        logic dn;
        run_op(OP_DIVU, 32'd100, 32'd7, bc, off, r, dn);
        checks++;
        if (r !== 32'h0000000E) begin
            failures++;
            $display("[TB] FAIL divu_result: got %h expected 0000000e", r);
        end
        checks++;
        if (off !== 32) begin
            failures++;
            $display("[TB] FAIL divu_latency: got %0d expected 32", off);
        end
        checks++;
        if (bc !== 32) begin
            failures++;
            $display("[TB] FAIL divu_busy_cycles: got %0d expected 32", bc);
        end
        checks++;
        if (dn !== 1'b0) begin
            failures++;
            $display("[TB] FAIL divu_done_pulse: got %b expected 0", dn);
        end
        run_op(OP_REMU, 32'd100, 32'd7, bc, off, r, dn);
        checks++;
        if (r !== 32'h00000002) begin
            failures++;
            $display("[TB] FAIL remu_result: got %h expected 00000002", r);
        end
        checks++;
        if (off !== 32) begin
            failures++;
            $display("[TB] FAIL remu_latency: got %0d expected 32", off);
        end
    endtask

    task automatic test_signed();
        int bc, off;
        logic [31:0] r;
        logic dn;
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, bc, off, r, dn);
        checks++;
        if (r !== 32'hFFFFFFFD) begin
            failures++;
            $display("[TB] FAIL div_neg_dividend: got %h expected fffffffd", r);
        end
        run_op(OP_REM, 32'hFFFFFFF9, 32'd2, bc, off, r, dn);
        checks++;
        if (r !== 32'hFFFFFFFF) begin
            failures++;
            $display("[TB] FAIL rem_neg_dividend: got %h expected ffffffff", r);
        end
        run_op(OP_DIV, 32'd7, 32'hFFFFFFFE, bc, off, r, dn);
        checks++;
        if (r !== 32'hFFFFFFFD) begin
            failures++;
            $display("[TB] FAIL div_neg_divisor: got %h expected fffffffd", r);
        end
        run_op(OP_REM, 32'd7, 32'hFFFFFFFE, bc, off, r, dn);
        checks++;
        if (r !== 32'h00000001) begin
            failures++;
            $display("[TB] FAIL rem_neg_divisor: got %h expected 00000001", r);
        end
    endtask

    task automatic test_div_zero();
        int bc, off;
        logic [31:0] r;
        logic dn;
        run_op(OP_DIVU, 32'd5, 32'd0, bc, off, r, dn);
        checks++;
        if (r !== 32'hFFFFFFFF) begin
            failures++;
            $display("[TB] FAIL divu_by_zero: got %h expected ffffffff", r);
        end
        checks++;
        if (off !== 0 || bc !== 0) begin
            failures++;
            $display("[TB] FAIL divu_by_zero_timing: got off=%0d busy=%0d expected off=0 busy=0", off, bc);
        end
        run_op(OP_DIV, 32'd5, 32'd0, bc, off, r, dn);
        checks++;
        if (r !== 32'hFFFFFFFF) begin
            failures++;
            $display("[TB] FAIL div_by_zero: got %h expected ffffffff", r);
        end
        checks++;
        if (off !== 0 || bc !== 0) begin
            failures++;
            $display("[TB] FAIL div_by_zero_timing: got off=%0d busy=%0d expected off=0 busy=0", off, bc);
        end
        run_op(OP_REMU, 32'd5, 32'd0, bc, off, r, dn);
        checks++;
        if (r !== 32'h00000005) begin
            failures++;
            $display("[TB] FAIL remu_by_zero: got %h expected 00000005", r);
        end
        checks++;
        if (dn !== 1'b0) begin
            failures++;
            $display("[TB] FAIL remu_by_zero_done_pulse: got %b expected 0", dn);
        end
    endtask

    task automatic test_overflow();
        int bc, off;
        logic [31:0] r;
        logic dn;
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, bc, off, r, dn);
        checks++;
        if (r !== 32'h80000000) begin
            failures++;
            $display("[TB] FAIL div_overflow: got %h expected 80000000", r);
        end
        checks++;
        if (off !== 0 || bc !== 0) begin
            failures++;
            $display("[TB] FAIL div_overflow_timing: got off=%0d busy=%0d expected off=0 busy=0", off, bc);
        end
        run_op(OP_REM, 32'h80000000, 32'hFFFFFFFF, bc, off, r, dn);
        checks++;
        if (r !== 32'h00000000) begin
            failures++;
            $display("[TB] FAIL rem_overflow: got %h expected 00000000", r);
        end
        run_op(OP_DIVU, 32'h80000000, 32'hFFFFFFFF, bc, off, r, dn);
        checks++;
        if (r !== 32'h00000000) begin
            failures++;
            $display("[TB] FAIL divu_large: got %h expected 00000000", r);
        end
        checks++;
        if (off !== 32) begin
            failures++;
            $display("[TB] FAIL divu_large_latency: got %0d expected 32", off);
        end
    endtask

    task automatic test_ignored_start();
        int off;
        DIV_OP = OP_DIVU;
        DATA1  = 32'd100;
        DATA2  = 32'd7;
        START  = 1'b1;
        tick();
        START = 1'b0;
        off   = 0;
        repeat (5) begin
            tick();
            off++;
        end
        DIV_OP = OP_DIV;
        DATA1  = 32'd1000;
        DATA2  = 32'd10;
        START  = 1'b1;
        tick();
        off++;
        START = 1'b0;
        while (DONE !== 1'b1 && off < 100) begin
            tick();
            off++;
        end
        checks++;
        if (off !== 32) begin
            failures++;
            $display("[TB] FAIL ignored_start_latency: got %0d expected 32", off);
        end
        checks++;
        if (RESULT !== 32'h0000000E) begin
            failures++;
            $display("[TB] FAIL ignored_start_result: got %h expected 0000000e", RESULT);
        end
        tick();
    endtask

    task automatic test_flush();
        int bc, off;
        logic [31:0] r;
        logic dn;
        DIV_OP = OP_DIVU;
        DATA1  = 32'd1000;
        DATA2  = 32'd3;
        START  = 1'b1;
        tick();
        START = 1'b0;
        repeat (9) tick();
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        checks++;
        if (BUSY !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_busy: got %b expected 0", BUSY);
        end
        checks++;
        if (DONE !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_done: got %b expected 0", DONE);
        end
        checks++;
        if (RESULT !== 32'h0000000E) begin
            failures++;
            $display("[TB] FAIL flush_result_held: got %h expected 0000000e", RESULT);
        end
        run_op(OP_DIVU, 32'hFFFFFFFF, 32'd3, bc, off, r, dn);
        checks++;
        if (r !== 32'h55555555) begin
            failures++;
            $display("[TB] FAIL after_flush_result: got %h expected 55555555", r);
        end
        checks++;
        if (off !== 32 || bc !== 32) begin
            failures++;
            $display("[TB] FAIL after_flush_timing: got off=%0d busy=%0d expected off=32 busy=32", off, bc);
        end
        // FLUSH together with START in IDLE must not launch anything.
        DIV_OP = OP_DIVU;
        DATA1  = 32'd9;
        DATA2  = 32'd3;
        START  = 1'b1;
        FLUSH  = 1'b1;
        tick();
        START = 1'b0;
        FLUSH = 1'b0;
        checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_start_idle: got busy=%b done=%b expected busy=0 done=0", BUSY, DONE);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        DIV_OP = OP_DIVU;
        DATA1  = 32'd1000;
        DATA2  = 32'd3;
        START  = 1'b1;
        tick();
        START = 1'b0;
        repeat (19) tick();
        RESET = 1'b1;
        START = 1'b1;
        DATA1 = 32'd50;
        DATA2 = 32'd5;
        tick();
        checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid_ctrl: got busy=%b done=%b expected busy=0 done=0", BUSY, DONE);
        end
        checks++;
        if (RESULT !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_mid_result: got %h expected 00000000", RESULT);
        end
        tick();
        checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_with_start: got busy=%b done=%b expected busy=0 done=0", BUSY, DONE);
        end
        RESET = 1'b0;
        START = 1'b0;
        seen  = 0;
        repeat (40) begin
            tick();
            if (DONE === 1'b1 || BUSY === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("[TB] FAIL reset_mid_quiet: got %0d active cycles expected 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_ignored_start();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
